gpu_l1_cache_nb: RTL and testbench

//   Parametrised, non-blocking, set-associative GPU L1 data cache with a pending request table (PRT).

---
 rtl/gpu_l1_cache_nb_if.sv | 43 ++++
 rtl/gpu_l1_cache_nb.sv | 255 +++++++++++++++++++++++++
 tb/tb_gpu_l1_cache_nb.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_l1_cache_nb_if.sv
// Bus bundle of the non-blocking GPU L1 data cache.
//   req_*/rsp_* : SM load unit lookup and response, mem_* : fill path to L2,
//   inv_req/inv_ack : whole-cache invalidate, prt_count : pending request table occupancy.
// slave = the cache itself, master = the SM/L2 environment around it.
interface gpu_l1_cache_nb_if #(
  parameter int ADDR_W    = 13,
  parameter int ID_W      = 4,
  parameter int LINE_BITS = 256,
  parameter int PRT_W     = 3
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic [ID_W-1:0]      req_id;
  logic                 rsp_valid;
  logic                 rsp_hit;
  logic [ID_W-1:0]      rsp_id;
  logic [LINE_BITS-1:0] rsp_data;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic [PRT_W-1:0]     mem_req_tag;
  logic                 mem_rsp_valid;
  logic [PRT_W-1:0]     mem_rsp_tag;
  logic [LINE_BITS-1:0] mem_rsp_data;
  logic                 inv_req;
  logic                 inv_ack;
  logic [PRT_W:0]       prt_count;

  modport slave (
    input  req_valid, req_addr, req_id, mem_req_ready,
           mem_rsp_valid, mem_rsp_tag, mem_rsp_data, inv_req,
    output req_ready, rsp_valid, rsp_hit, rsp_id, rsp_data,
           mem_req_valid, mem_req_addr, mem_req_tag, inv_ack, prt_count
  );

  modport master (
    output req_valid, req_addr, req_id, mem_req_ready,
           mem_rsp_valid, mem_rsp_tag, mem_rsp_data, inv_req,
    input  req_ready, rsp_valid, rsp_hit, rsp_id, rsp_data,
           mem_req_valid, mem_req_addr, mem_req_tag, inv_ack, prt_count
  );
endinterface

// File: rtl/gpu_l1_cache_nb.sv
// Non-blocking set-associative read-only GPU L1 data cache with a pending request table (PRT).
// Latency: hit response 1 cycle after acceptance; a miss responds 1 cycle after its L2 fill arrives.
// Backpressure: req_ready drops on fill, invalidate, full PRT or a request to an already pending line;
//   rsp has none; mem_req holds addr/tag stable until mem_req_ready; fills are always accepted.
// Ports: clk, rst_n (async active-low) plus bus (gpu_l1_cache_nb_if.slave) carrying req/rsp,
//   mem_req/mem_rsp, inv_req/inv_ack and prt_count.
module gpu_l1_cache_nb #(
  parameter int ADDR_W    = 13,
  parameter int SETS      = 8,
  parameter int WAYS      = 4,
  parameter int LINE_BITS = 256,
  parameter int PRT_DEPTH = 6,
  parameter int ID_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gpu_l1_cache_nb_if.slave    bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - SET_W;
  localparam int PRT_W = $clog2(PRT_DEPTH);
  localparam int CNT_W = PRT_W + 1;

  typedef enum logic [1:0] {INV_IDLE, INV_DRAIN, INV_CLEAR} inv_state_e;

  // line storage
  logic [WAYS-1:0]      line_vld [SETS];
  logic [TAG_W-1:0]     line_tag [SETS][WAYS];
  logic [LINE_BITS-1:0] line_dat [SETS][WAYS];
  logic [WAY_W-1:0]     rr_ptr   [SETS];

  // pending request table
  logic [PRT_DEPTH-1:0] prt_vld;
  logic [PRT_DEPTH-1:0] prt_iss;
  logic [ADDR_W-1:0]    prt_addr [PRT_DEPTH];
  logic [ID_W-1:0]      prt_id   [PRT_DEPTH];
  logic [CNT_W-1:0]     prt_cnt;

  // issue lock keeps a presented-but-unaccepted fill request stable
  logic                 issue_lock;
  logic [PRT_W-1:0]     lock_tag;

  logic                 rsp_valid_q, rsp_hit_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [LINE_BITS-1:0] rsp_data_q;

  inv_state_e           inv_state;
  logic                 inv_armed;
  logic                 inv_ack_q;
  logic                 inv_busy;

  // request-side lookup
  logic [SET_W-1:0]     req_set;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic [LINE_BITS-1:0] hit_dat;
  logic                 pend_match;
  logic [PRT_W-1:0]     alloc_idx;
  logic                 req_rdy;
  logic                 do_acc;
  logic                 do_alloc;

  assign req_set = bus.req_addr[SET_W-1:0];
  assign req_tag = bus.req_addr[ADDR_W-1:SET_W];

  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && line_vld[req_set][w] && (line_tag[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_dat = line_dat[req_set][w];
      end
    end
  end

  always_comb begin
    pend_match = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < PRT_DEPTH; i++) begin
      if (prt_vld[i] && (prt_addr[i] == bus.req_addr)) pend_match = 1'b1;
    end
    for (int i = PRT_DEPTH - 1; i >= 0; i--) begin
      if (!prt_vld[i]) alloc_idx = PRT_W'(i);
    end
  end

  assign inv_busy = (inv_state != INV_IDLE);
  // A fill in the same cycle blocks requests so hit and fill responses never collide.
  assign req_rdy  = !bus.mem_rsp_valid && !inv_busy &&
                    (prt_cnt < CNT_W'(PRT_DEPTH)) && !pend_match;
  assign do_acc   = bus.req_valid && req_rdy;
  assign do_alloc = do_acc && !hit;

  // fill issue: lowest pending entry unless one is already presented
  logic                 pend_any;
  logic [PRT_W-1:0]     pend_idx;
  logic [PRT_W-1:0]     sel_tag;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 mem_hs;

  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int i = PRT_DEPTH - 1; i >= 0; i--) begin
      if (prt_vld[i] && !prt_iss[i]) begin
        pend_any = 1'b1;
        pend_idx = PRT_W'(i);
      end
    end
    sel_tag  = issue_lock ? lock_tag : pend_idx;
    sel_addr = '0;
    for (int i = 0; i < PRT_DEPTH; i++) begin
      if (sel_tag == PRT_W'(i)) sel_addr = prt_addr[i];
    end
  end

  assign mem_hs = (issue_lock || pend_any) && bus.mem_req_ready;

  // fill return: only entries that are valid and already issued are honoured
  logic                 fill_ok;
  logic [ADDR_W-1:0]    fill_addr;
  logic [ID_W-1:0]      fill_id;
  logic [SET_W-1:0]     fill_set;
  logic [WAY_W-1:0]     victim;
  logic                 found_free;
  logic [WAY_W-1:0]     rr_nxt;

  always_comb begin
    fill_ok   = 1'b0;
    fill_addr = '0;
    fill_id   = '0;
    for (int i = 0; i < PRT_DEPTH; i++) begin
      if (bus.mem_rsp_tag == PRT_W'(i)) begin
        fill_addr = prt_addr[i];
        fill_id   = prt_id[i];
        fill_ok   = bus.mem_rsp_valid && prt_vld[i] && prt_iss[i];
      end
    end
    fill_set   = fill_addr[SET_W-1:0];
    found_free = 1'b0;
    victim     = rr_ptr[fill_set];
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !line_vld[fill_set][w]) begin
        found_free = 1'b1;
        victim     = WAY_W'(w);
      end
    end
    rr_nxt = (rr_ptr[fill_set] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[fill_set] + 1'b1;
  end

  // control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        line_vld[s] <= '0;
        rr_ptr[s]   <= '0;
      end
      prt_vld     <= '0;
      prt_iss     <= '0;
      prt_cnt     <= '0;
      issue_lock  <= 1'b0;
      lock_tag    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (inv_state == INV_CLEAR) begin
        for (int s = 0; s < SETS; s++) begin
          line_vld[s] <= '0;
          rr_ptr[s]   <= '0;
        end
      end
      if (fill_ok) begin
        line_vld[fill_set][victim] <= 1'b1;
        rr_ptr[fill_set]           <= rr_nxt;
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= 1'b0;
        rsp_id_q    <= fill_id;
        rsp_data_q  <= bus.mem_rsp_data;
      end else if (do_acc && hit) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= 1'b1;
        rsp_id_q    <= bus.req_id;
        rsp_data_q  <= hit_dat;
      end
      for (int i = 0; i < PRT_DEPTH; i++) begin
        if (fill_ok && (bus.mem_rsp_tag == PRT_W'(i))) begin
          prt_vld[i] <= 1'b0;
          prt_iss[i] <= 1'b0;
        end
        if (do_alloc && (alloc_idx == PRT_W'(i))) begin
          prt_vld[i] <= 1'b1;
          prt_iss[i] <= 1'b0;
        end
        if (mem_hs && (sel_tag == PRT_W'(i))) prt_iss[i] <= 1'b1;
      end
      issue_lock <= (issue_lock || pend_any) && !bus.mem_req_ready;
      lock_tag   <= sel_tag;
      prt_cnt    <= prt_cnt + CNT_W'(do_alloc) - CNT_W'(fill_ok);
    end
  end

  // payload storage, no reset needed: qualified by line_vld / prt_vld
  always_ff @(posedge clk) begin
    if (fill_ok) begin
      line_tag[fill_set][victim] <= fill_addr[ADDR_W-1:SET_W];
      line_dat[fill_set][victim] <= bus.mem_rsp_data;
    end
    if (do_alloc) begin
      prt_addr[alloc_idx] <= bus.req_addr;
      prt_id[alloc_idx]   <= bus.req_id;
    end
  end

  // invalidate FSM: drain outstanding misses, clear in one cycle, then wait for inv_req to drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_state <= INV_IDLE;
      inv_armed <= 1'b1;
      inv_ack_q <= 1'b0;
    end else begin
      inv_ack_q <= 1'b0;
      case (inv_state)
        INV_IDLE: begin
          if (!bus.inv_req)   inv_armed <= 1'b1;
          else if (inv_armed) inv_state <= INV_DRAIN;
        end
        INV_DRAIN: begin
          if (prt_cnt == '0) inv_state <= INV_CLEAR;
        end
        INV_CLEAR: begin
          inv_ack_q <= 1'b1;
          inv_armed <= 1'b0;
          inv_state <= INV_IDLE;
        end
        default: inv_state <= INV_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_rdy;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.mem_req_valid = issue_lock || pend_any;
  assign bus.mem_req_addr  = sel_addr;
  assign bus.mem_req_tag   = sel_tag;
  assign bus.inv_ack       = inv_ack_q;
  assign bus.prt_count     = prt_cnt;
endmodule

// File: tb/tb_gpu_l1_cache_nb.sv
// Directed + randomized bench for gpu_l1_cache_nb against a line/entry-level reference model.
module tb_gpu_l1_cache_nb;
  localparam int ADDR_W = 13, SETS = 8, WAYS = 4, LINE_BITS = 256, PRT_DEPTH = 6, ID_W = 4;
  localparam int SET_W = 3, PRT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_l1_cache_nb_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LINE_BITS(LINE_BITS), .PRT_W(PRT_W)) bus ();

  gpu_l1_cache_nb #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .LINE_BITS(LINE_BITS),
                    .PRT_DEPTH(PRT_DEPTH), .ID_W(ID_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // reference model: cache lines keyed by full address, PRT entries, invalidate busy flag
  bit                   m_cv [SETS][WAYS];
  logic [ADDR_W-1:0]    m_ca [SETS][WAYS];
  logic [LINE_BITS-1:0] m_cd [SETS][WAYS];
  int                   m_rr [SETS];
  bit                   m_pv [PRT_DEPTH];
  bit                   m_pi [PRT_DEPTH];
  logic [ADDR_W-1:0]    m_pa [PRT_DEPTH];
  logic [ID_W-1:0]      m_pid[PRT_DEPTH];
  bit                   m_inv_busy;
  int                   last_alloc;
  bit                   last_miss;

  task automatic chk(input string tag, input logic [LINE_BITS-1:0] obs, input logic [LINE_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_BITS-1:0] rnd_line();
    logic [LINE_BITS-1:0] d;
    for (int i = 0; i < LINE_BITS / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int set_of(input logic [ADDR_W-1:0] a);
    return int'(a) % SETS;
  endfunction

  function automatic int m_lookup(input logic [ADDR_W-1:0] a);
    for (int w = 0; w < WAYS; w++) if (m_cv[set_of(a)][w] && m_ca[set_of(a)][w] == a) return w;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < PRT_DEPTH; k++) n += int'(m_pv[k]);
    return n;
  endfunction

  function automatic bit m_pend(input logic [ADDR_W-1:0] a);
    for (int k = 0; k < PRT_DEPTH; k++) if (m_pv[k] && m_pa[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input logic [ADDR_W-1:0] a);
    return !m_inv_busy && (m_count() < PRT_DEPTH) && !m_pend(a);
  endfunction

  function automatic logic [ADDR_W-1:0] new_addr(input int set_lo, input int set_hi);
    logic [ADDR_W-1:0] a;
    do begin
      a = ADDR_W'($urandom);
      a[SET_W-1:0] = SET_W'($urandom_range(set_lo, set_hi));
    end while (m_lookup(a) >= 0 || m_pend(a));
    return a;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_cv[s][w] = 1'b0;
    end
    for (int k = 0; k < PRT_DEPTH; k++) begin m_pv[k] = 1'b0; m_pi[k] = 1'b0; end
    m_inv_busy = 1'b0;
  endtask

  // all tasks start and end at a falling edge
  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
    bit r;
    int w, k;
    r = m_ready(a);
    w = m_lookup(a);
    last_miss = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_id = id;
    #1;
    chk("req_ready", bus.req_ready, r);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (r && w >= 0) begin
      chk("hit_rsp_valid", bus.rsp_valid, 1);
      chk("hit_rsp_hit", bus.rsp_hit, 1);
      chk("hit_rsp_id", bus.rsp_id, id);
      chk("hit_rsp_data", bus.rsp_data, m_cd[set_of(a)][w]);
    end else begin
      chk("no_rsp_on_miss_or_stall", bus.rsp_valid, 0);
      if (r) begin
        k = 0;
        while (m_pv[k]) k++;
        m_pv[k] = 1'b1; m_pi[k] = 1'b0; m_pa[k] = a; m_pid[k] = id;
        last_alloc = k;
        last_miss = 1'b1;
      end
    end
    chk("prt_count", bus.prt_count, m_count());
  endtask

  task automatic do_issue();
    int k = -1;
    for (int i = PRT_DEPTH - 1; i >= 0; i--) if (m_pv[i] && !m_pi[i]) k = i;
    chk("mem_req_valid", bus.mem_req_valid, (k >= 0));
    if (k < 0) return;
    chk("mem_req_addr", bus.mem_req_addr, m_pa[k]);
    chk("mem_req_tag", bus.mem_req_tag, k);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    m_pi[k] = 1'b1;
  endtask

  task automatic do_fill(input int tag, input logic [LINE_BITS-1:0] d);
    int s, v;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = PRT_W'(tag); bus.mem_rsp_data = d;
    #1;
    chk("fill_blocks_req", bus.req_ready, 0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    if (tag < PRT_DEPTH && m_pv[tag] && m_pi[tag]) begin
      chk("fill_rsp_valid", bus.rsp_valid, 1);
      chk("fill_rsp_hit", bus.rsp_hit, 0);
      chk("fill_rsp_id", bus.rsp_id, m_pid[tag]);
      chk("fill_rsp_data", bus.rsp_data, d);
      s = set_of(m_pa[tag]);
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !m_cv[s][w]) v = w;
      if (v < 0) v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
      m_cv[s][v] = 1'b1; m_ca[s][v] = m_pa[tag]; m_cd[s][v] = d;
      m_pv[tag] = 1'b0; m_pi[tag] = 1'b0;
    end else begin
      chk("stale_fill_ignored", bus.rsp_valid, 0);
    end
    chk("prt_count_after_fill", bus.prt_count, m_count());
  endtask

  logic [ADDR_W-1:0] a, h, d_addr, m1, m2;
  logic [ADDR_W-1:0] blk [5];
  logic [ADDR_W-1:0] pool [12];
  int                ent [6];
  int                order [6] = '{4, 1, 5, 0, 3, 2};
  int                k1, k2, kd, op, k, start;
  bit                got;

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_id = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0; bus.mem_rsp_data = '0;
    bus.inv_req = 1'b0;
    m_reset();

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_inv_ack", bus.inv_ack, 0);
    chk("rst_prt_count", bus.prt_count, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // cold miss, fill, re-request hits
    do_req(13'h0A3, 4'd5);
    chk("cold_mem_addr", bus.mem_req_addr, 13'h0A3);
    do_issue();
    @(negedge clk); @(negedge clk);
    do_fill(0, rnd_line());
    do_req(13'h0A3, 4'd9);

    // fill the PRT, stall, out-of-order fills
    for (int i = 0; i < 6; i++) begin
      do_req(new_addr(0, 6), ID_W'($urandom));
      ent[i] = last_alloc;
    end
    do_req(new_addr(0, 6), 4'd1);
    for (int i = 0; i < 6; i++) do_issue();
    do_issue();
    for (int i = 0; i < 6; i++) do_fill(order[i], rnd_line());

    // five lines in set 7: the fifth evicts the first, the second survives
    for (int i = 0; i < 5; i++) begin
      blk[i] = {10'(i * 97 + 5), 3'd7};
      do_req(blk[i], ID_W'(i));
      do_issue();
      do_fill(last_alloc, rnd_line());
    end
    do_req(blk[0], 4'd11);
    kd = last_alloc;
    do_req(blk[1], 4'd12);
    do_issue();
    do_fill(kd, rnd_line());

    // request to a pending line stalls until the fill, then hits
    d_addr = new_addr(6, 6);
    do_req(d_addr, 4'd3);
    kd = last_alloc;
    do_issue();
    bus.req_valid = 1'b1; bus.req_addr = d_addr; bus.req_id = 4'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dup_stall_ready", bus.req_ready, 0);
      @(negedge clk);
      chk("dup_stall_no_rsp", bus.rsp_valid, 0);
    end
    do_fill(kd, rnd_line());
    do_req(d_addr, 4'd4);

    // invalidate with two misses outstanding
    h = d_addr;
    m1 = new_addr(0, 7); do_req(m1, 4'd6); k1 = last_alloc; do_issue();
    m2 = new_addr(0, 7); do_req(m2, 4'd7); k2 = last_alloc; do_issue();
    bus.inv_req = 1'b1;
    @(negedge clk);
    m_inv_busy = 1'b1;
    do_req(h, 4'd8);
    chk("inv_no_early_ack", bus.inv_ack, 0);
    do_fill(k1, rnd_line());
    chk("inv_no_ack_one_pending", bus.inv_ack, 0);
    do_fill(k2, rnd_line());
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (bus.inv_ack) got = 1'b1;
      else @(negedge clk);
    end
    chk("inv_ack_seen", got, 1);
    bus.inv_req = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_cv[s][w] = 1'b0;
    end
    m_inv_busy = 1'b0;
    @(negedge clk);
    chk("inv_ack_pulse", bus.inv_ack, 0);
    do_req(h, 4'd2);
    do_issue();

    // randomized traffic on two sets with a small address pool
    for (int i = 0; i < 12; i++) pool[i] = {5'($urandom), 5'(i / 2), 3'(i % 2)};
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        a = pool[$urandom_range(0, 11)];
        do_req(a, ID_W'($urandom));
        if (last_miss) do_issue();
      end else begin
        k = -1;
        start = $urandom_range(0, PRT_DEPTH - 1);
        for (int j = 0; j < PRT_DEPTH; j++)
          if (k < 0 && m_pv[(start + j) % PRT_DEPTH] && m_pi[(start + j) % PRT_DEPTH]) k = (start + j) % PRT_DEPTH;
        if (k < 0 || $urandom_range(0, 4) == 0) k = $urandom_range(0, 7);
        do_fill(k, rnd_line());
      end
    end
    for (int i = 0; i < PRT_DEPTH; i++) if (m_pv[i]) do_fill(i, rnd_line());

    // reset with three misses outstanding; a late fill must be ignored
    for (int i = 0; i < 3; i++) begin
      do_req(new_addr(0, 7), ID_W'(i));
      do_issue();
    end
    chk("pre_rst_count", bus.prt_count, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_prt_count", bus.prt_count, 0);
    chk("midrst_mem_req_valid", bus.mem_req_valid, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_fill(1, rnd_line());
    chk("post_rst_mem_req_valid", bus.mem_req_valid, 0);
    do_req(13'h0A3, 4'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
